// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues one load/store at a time to a multi-cycle memory
// and registers results for write-back. Define MEM_TIMEOUT_EN to enable the WAIT abort timer.
module mem_access_ctrl #(
    parameter int N = 16
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    input  logic [N-1:0] execute_rst,
    input  logic         mem_busy,
    input  logic         mem_done,
    input  logic [N-1:0] mem_rdata,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         mem_rd,
    output logic         mem_wr,
    output logic         pipe_stall,
    output logic         out_valid,
    output logic [N-1:0] MemReadRst,
    output logic [N-1:0] ex_rst_out,
    output logic         err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state, state_nxt;
    logic   start;
    logic   timeout_hit;
    logic   is_load_p0;

    assign start     = in_valid & (MemRead | MemWrite) & ~addr[0] & ~(MemRead & MemWrite);
    assign mem_addr  = addr;
    assign mem_wdata = wdata;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt;

    // cnt holds the number of WAIT cycles already spent without completion
    assign timeout_hit = (state == S_WAIT) & ~mem_done & (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_IDLE) begin
            cnt <= '0;
        end else if (!mem_done) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && !mem_busy) state_nxt = S_WAIT;
            S_WAIT:  if (mem_done || timeout_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        pipe_stall = 1'b0;
        case (state)
            S_IDLE: begin
                mem_rd     = start & ~mem_busy & MemRead;
                mem_wr     = start & ~mem_busy & MemWrite;
                pipe_stall = start;
            end
            S_WAIT: begin
                pipe_stall = ~mem_done & ~timeout_hit;
            end
            default: ;
        endcase
    end

    // Write-back register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            err        <= 1'b0;
            MemReadRst <= '0;
            ex_rst_out <= '0;
            is_load_p0 <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !mem_busy) begin
                        ex_rst_out <= execute_rst;
                        is_load_p0 <= MemRead;
                    end else if (in_valid && !start) begin
                        // a rejected memory op is necessarily misaligned or read+write
                        out_valid  <= 1'b1;
                        ex_rst_out <= execute_rst;
                        err        <= MemRead | MemWrite;
                    end
                end
                S_WAIT: begin
                    if (mem_done) begin
                        out_valid <= 1'b1;
                        err       <= 1'b0;
                        if (is_load_p0) MemReadRst <= mem_rdata;
                    end else if (timeout_hit) begin
                        out_valid  <= 1'b1;
                        err        <= 1'b1;
                        MemReadRst <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_mem_access_ctrl;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, MemRead, MemWrite;
    logic [N-1:0] addr, wdata, execute_rst;
    logic         mem_busy, mem_done;
    logic [N-1:0] mem_rdata;
    logic [N-1:0] mem_addr, mem_wdata;
    logic         mem_rd, mem_wr, pipe_stall, out_valid, err;
    logic [N-1:0] MemReadRst, ex_rst_out;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .wdata(wdata), .execute_rst(execute_rst), .mem_busy(mem_busy),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .pipe_stall(pipe_stall), .out_valid(out_valid),
        .MemReadRst(MemReadRst), .ex_rst_out(ex_rst_out), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        mem_busy = 1'b0; mem_done = 1'b0;
    endtask

    // Holds one op on the inputs until the memory completes it, tallying handshake activity.
    task automatic run_access(input logic ld, input logic st, input logic [15:0] a,
                              input logic [15:0] wd, input logic [15:0] exr,
                              input logic [15:0] rdat, input int busy_n, input int done_after,
                              output int stalls, output int rd_pulses, output int wr_pulses,
                              output int req_cycle, output logic [15:0] wd_seen);
        stalls = 0; rd_pulses = 0; wr_pulses = 0; req_cycle = -1; wd_seen = '0;
        in_valid = 1'b1; MemRead = ld; MemWrite = st;
        addr = a; wdata = wd; execute_rst = exr;
        for (int c = 0; c <= busy_n + done_after; c++) begin
            mem_busy  = (c < busy_n);
            mem_done  = (c == busy_n + done_after);
            mem_rdata = mem_done ? rdat : 16'hDEAD;
            #1;
            if (pipe_stall) stalls++;
            if (mem_rd) begin rd_pulses++; req_cycle = c; end
            if (mem_wr) begin wr_pulses++; req_cycle = c; wd_seen = mem_wdata; end
            next_cycle();
        end
        idle_inputs();
    endtask

    int          stalls, rdp, wrp, reqc, abort_c;
    logic [15:0] wds;

    initial begin
        rst = 1'b1;
        idle_inputs();
        addr = '0; wdata = '0; execute_rst = '0; mem_rdata = '0;

        // Reset
        @(negedge clk);
        next_cycle();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_MemReadRst", MemReadRst, 0);
        check("rst_ex_rst_out", ex_rst_out, 0);

        // ALU op
        in_valid = 1'b1; addr = 16'h0010; execute_rst = 16'h1234;
        #1;
        check("alu_stall", pipe_stall, 0);
        check("alu_mem_rd", mem_rd, 0);
        next_cycle();
        idle_inputs();
        #1;
        check("alu_out_valid", out_valid, 1);
        check("alu_ex_rst_out", ex_rst_out, 16'h1234);
        check("alu_err", err, 0);
        check("alu_stall_after", pipe_stall, 0);
        next_cycle();
        check("alu_pulse_end", out_valid, 0);

        // Load, done 3 cycles after the request
        run_access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1111, 16'hBEEF, 0, 3,
                   stalls, rdp, wrp, reqc, wds);
        check("ld_stalls", stalls, 3);
        check("ld_rd_pulses", rdp, 1);
        check("ld_wr_pulses", wrp, 0);
        check("ld_req_cycle", reqc, 0);
        check("ld_out_valid", out_valid, 1);
        check("ld_MemReadRst", MemReadRst, 16'hBEEF);
        check("ld_err", err, 0);
        check("ld_ex_rst_out", ex_rst_out, 16'h1111);
        next_cycle();
        check("ld_pulse_end", out_valid, 0);

        // Store with memory busy for two cycles
        run_access(1'b0, 1'b1, 16'h0042, 16'h5A5A, 16'h2222, 16'h0BAD, 2, 1,
                   stalls, rdp, wrp, reqc, wds);
        check("st_stalls", stalls, 3);
        check("st_wr_pulses", wrp, 1);
        check("st_rd_pulses", rdp, 0);
        check("st_req_cycle", reqc, 2);
        check("st_mem_wdata", wds, 16'h5A5A);
        check("st_out_valid", out_valid, 1);
        check("st_MemReadRst_kept", MemReadRst, 16'hBEEF);
        check("st_err", err, 0);
        check("st_ex_rst_out", ex_rst_out, 16'h2222);
        next_cycle();

        // Misaligned load
        in_valid = 1'b1; MemRead = 1'b1; addr = 16'h0041; execute_rst = 16'h3333;
        #1;
        check("mis_mem_rd", mem_rd, 0);
        check("mis_stall", pipe_stall, 0);
        next_cycle();
        idle_inputs();
        check("mis_out_valid", out_valid, 1);
        check("mis_err", err, 1);
        check("mis_ex_rst_out", ex_rst_out, 16'h3333);

        // Read and write together
        in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; addr = 16'h0044;
        #1;
        check("rw_no_request", {mem_rd, mem_wr}, 0);
        next_cycle();
        idle_inputs();
        check("rw_out_valid", out_valid, 1);
        check("rw_err", err, 1);

        // A clean ALU op clears err
        in_valid = 1'b1; addr = 16'h0000; execute_rst = 16'h5555;
        next_cycle();
        idle_inputs();
        check("alu2_err", err, 0);
        check("alu2_ex_rst_out", ex_rst_out, 16'h5555);

`ifdef MEM_TIMEOUT_EN
        // Load that never completes: abort on the 64th WAIT cycle
        abort_c = -1;
        in_valid = 1'b1; MemRead = 1'b1; addr = 16'h0048;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (!pipe_stall && c > 0) begin
                abort_c = c;
                next_cycle();
                break;
            end
            next_cycle();
        end
        idle_inputs();
        check("to_abort_cycle", abort_c, 64);
        check("to_out_valid", out_valid, 1);
        check("to_err", err, 1);
        check("to_MemReadRst", MemReadRst, 0);
        next_cycle();
`endif

        // Reset while an access is outstanding
        in_valid = 1'b1; MemRead = 1'b1; addr = 16'h0046; execute_rst = 16'h6666;
        next_cycle();
        next_cycle();
        #1;
        check("rw_wait_stall", pipe_stall, 1);
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'hCAFE;
        #1;
        check("rstw_stall", pipe_stall, 0);
        check("rstw_out_valid0", out_valid, 0);
        next_cycle();
        mem_done = 1'b0;
        check("rstw_out_valid1", out_valid, 0);
        check("rstw_MemReadRst", MemReadRst, 0);
        check("rstw_ex_rst_out", ex_rst_out, 0);
        next_cycle();
        check("rstw_out_valid2", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
